// File: rtl/uart_pkg.sv
// Shared definitions for the receive buffer: FIFO sizing and FSM state encodings.
package uart_pkg;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [0:0] {
        C_IDLE = 1'b0,
        C_WAIT = 1'b1
    } cap_state_e;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_REQ  = 2'd1,
        I_SRV  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/uart_rx_irq_fifo_if.sv
// Bus bundle between uart_rx / Z80 port logic (master) and the receive buffer (slave).
interface uart_rx_irq_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] rx_data;
    logic              rx_data_ready;
    logic              rx_clear;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic              rx_avail;
    logic              fifo_full;
    logic [AW:0]       count;
    logic              overrun;
    logic              overrun_clr;
    logic              int_en;
    logic              int_ack;
    logic              int_n;

    modport slave (
        input  rx_data, rx_data_ready, pop, overrun_clr, int_en, int_ack,
        output rx_clear, rd_data, rx_avail, fifo_full, count, overrun, int_n
    );

    modport master (
        output rx_data, rx_data_ready, pop, overrun_clr, int_en, int_ack,
        input  rx_clear, rd_data, rx_avail, fifo_full, count, overrun, int_n
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; push and pop may coincide.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Pointer and count update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since empty masks the read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_irq_fifo.sv
// Receive buffer: drains uart_rx into a FIFO and raises one Z80 interrupt per byte read.
module uart_rx_irq_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_irq_fifo_if.slave   bus
);

    cap_state_e        cap_state_q, cap_state_d;
    irq_state_e        irq_state_q, irq_state_d;
    logic              rx_clear_q, rx_clear_d;
    logic              overrun_q, overrun_d;
    logic              int_n_q, int_n_d;
    logic              overrun_set;
    logic              fifo_push;
    logic              fifo_full_w;
    logic              fifo_empty;
    logic              fifo_emptied;
    logic [AW:0]       fifo_count;
    logic [DATA_W-1:0] fifo_rdata;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (bus.rx_data),
        .pop   (bus.pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full_w),
        .empty (fifo_empty)
    );

    // Last entry leaves this cycle with nothing arriving to replace it.
    assign fifo_emptied = bus.pop & ~fifo_empty & ~fifo_push
                        & (fifo_count == (AW+1)'(1));

    // Capture FSM: take each byte once, hold rx_clear until uart_rx drops ready.
    always_comb begin
        cap_state_d = cap_state_q;
        rx_clear_d  = rx_clear_q;
        fifo_push   = 1'b0;
        overrun_set = 1'b0;
        case (cap_state_q)
            C_IDLE: begin
                if (bus.rx_data_ready) begin
                    rx_clear_d  = 1'b1;
                    cap_state_d = C_WAIT;
                    if (fifo_full_w && !bus.pop) begin
                        overrun_set = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            C_WAIT: begin
                if (!bus.rx_data_ready) begin
                    rx_clear_d  = 1'b0;
                    cap_state_d = C_IDLE;
                end
            end
            default: begin
                rx_clear_d  = 1'b0;
                cap_state_d = C_IDLE;
            end
        endcase
        overrun_d = overrun_set | (overrun_q & ~bus.overrun_clr);
    end

    // Interrupt FSM: request while data pending, quiet after ack until the CPU reads.
    always_comb begin
        irq_state_d = irq_state_q;
        case (irq_state_q)
            I_IDLE: begin
                if (!fifo_empty && bus.int_en) begin
                    irq_state_d = I_REQ;
                end
            end
            I_REQ: begin
                if (!bus.int_en || fifo_emptied) begin
                    irq_state_d = I_IDLE;
                end else if (bus.int_ack) begin
                    irq_state_d = I_SRV;
                end
            end
            I_SRV: begin
                if (bus.pop) begin
                    irq_state_d = I_IDLE;
                end
            end
            default: irq_state_d = I_IDLE;
        endcase
        int_n_d = (irq_state_d != I_REQ);
    end

    // State and registered-output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_state_q <= C_IDLE;
            irq_state_q <= I_IDLE;
            rx_clear_q  <= 1'b0;
            overrun_q   <= 1'b0;
            int_n_q     <= 1'b1;
        end else begin
            cap_state_q <= cap_state_d;
            irq_state_q <= irq_state_d;
            rx_clear_q  <= rx_clear_d;
            overrun_q   <= overrun_d;
            int_n_q     <= int_n_d;
        end
    end

    assign bus.rx_clear  = rx_clear_q;
    assign bus.rd_data   = fifo_rdata;
    assign bus.rx_avail  = ~fifo_empty;
    assign bus.fifo_full = fifo_full_w;
    assign bus.count     = fifo_count;
    assign bus.overrun   = overrun_q;
    assign bus.int_n     = int_n_q;

endmodule

// File: tb/tb_uart_rx_irq_fifo.sv
// Bench for uart_rx_irq_fifo: directed scenarios plus a randomized phase vs a queue model.
module tb_uart_rx_irq_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = FIFO_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_irq_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_irq_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: byte queue, sticky overrun, handshake-in-progress, interrupt view.
    logic [7:0] q[$];
    bit m_ovr, m_busy, m_req, m_srv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic compare_all(input string where);
        chk({where, ".count"},     32'(bus.count),     32'(q.size()));
        chk({where, ".rd_data"},   32'(bus.rd_data),   32'(exp_head()));
        chk({where, ".rx_avail"},  32'(bus.rx_avail),  32'(q.size() > 0));
        chk({where, ".fifo_full"}, 32'(bus.fifo_full), 32'(q.size() == DEPTH));
        chk({where, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
        chk({where, ".rx_clear"},  32'(bus.rx_clear),  32'(m_busy));
        chk({where, ".int_n"},     32'(bus.int_n),     32'(!m_req));
    endtask

    // One clock with the given inputs; the model applies the documented rules to that edge.
    task automatic step(input bit rdy, input logic [7:0] d, input bit p,
                        input bit clr, input bit ack, input string where);
        int  sz;
        bit  popped, cap, ovr_set, emptied;
        bus.rx_data_ready = rdy;
        bus.rx_data       = d;
        bus.pop           = p;
        bus.overrun_clr   = clr;
        bus.int_ack       = ack;
        @(posedge clk);
        sz      = q.size();
        popped  = p && (sz > 0);
        cap     = rdy && !m_busy;
        ovr_set = 1'b0;
        if (m_busy && !rdy) m_busy = 1'b0;
        else if (cap)       m_busy = 1'b1;
        if (popped) void'(q.pop_front());
        if (cap) begin
            if (sz < DEPTH || popped) q.push_back(d);
            else ovr_set = 1'b1;
        end
        m_ovr   = ovr_set | (m_ovr & !clr);
        emptied = popped && (q.size() == 0);
        if (m_srv) begin
            if (p) m_srv = 1'b0;
        end else if (m_req) begin
            if (!bus.int_en || emptied) m_req = 1'b0;
            else if (ack) begin
                m_req = 1'b0;
                m_srv = 1'b1;
            end
        end else if (sz > 0 && bus.int_en) begin
            m_req = 1'b1;
        end
        #1;
        compare_all(where);
    endtask

    task automatic push_byte(input logic [7:0] d, input bit p);
        step(1'b1, d, p, 1'b0, 1'b0, "push");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "push_rel");
    endtask

    // Synchronous reset for one edge; other inputs keep their current values.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        q.delete();
        m_ovr  = 1'b0;
        m_busy = 1'b0;
        m_req  = 1'b0;
        m_srv  = 1'b0;
        #1;
        compare_all("reset");
        chk("reset.int_n_high", 32'(bus.int_n), 32'd1);
        reset = 1'b0;
    endtask

    initial begin
        logic       rdy_l;
        logic [7:0] d_l;
        reset             = 1'b1;
        bus.rx_data       = 8'h00;
        bus.rx_data_ready = 1'b0;
        bus.pop           = 1'b0;
        bus.overrun_clr   = 1'b0;
        bus.int_en        = 1'b0;
        bus.int_ack       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: single byte through the handshake, interrupt one cycle after rx_avail
        bus.int_en = 1'b1;
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, "t1.cap");
        chk("t1.rd_data", 32'(bus.rd_data), 32'h41);
        chk("t1.int_n_not_yet", 32'(bus.int_n), 32'd1);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, "t1.hold");
        chk("t1.no_double_push", 32'(bus.count), 32'd1);
        chk("t1.rx_clear_held", 32'(bus.rx_clear), 32'd1);
        chk("t1.int_n_low", 32'(bus.int_n), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t1.rel");
        chk("t1.rx_clear_drop", 32'(bus.rx_clear), 32'd0);

        // 2: ack, read, no re-request; next byte requests again
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t2.ack");
        chk("t2.int_n_after_ack", 32'(bus.int_n), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t2.pop");
        chk("t2.count0", 32'(bus.count), 32'd0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t2.idle");
        chk("t2.no_rereq", 32'(bus.int_n), 32'd1);
        push_byte(8'h42, 1'b0);
        chk("t2.int_n_second", 32'(bus.int_n), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t2.ack2");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t2.pop2");

        // 3: overfill by one; overrun set wins against a simultaneous clear
        bus.int_en = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, "t3.overflow");
        chk("t3.full", 32'(bus.fifo_full), 32'd1);
        chk("t3.count16", 32'(bus.count), 32'd16);
        chk("t3.overrun_set_wins", 32'(bus.overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t3.rel");
        for (int i = 0; i < 16; i++) begin
            chk("t3.order", 32'(bus.rd_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t3.pop");
        end
        chk("t3.drained", 32'(bus.count), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "t3.clr");
        chk("t3.overrun_cleared", 32'(bus.overrun), 32'd0);

        // 4: push+pop while full, then run pointers past wrap
        for (int i = 0; i < 16; i++) push_byte(8'($urandom), 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, "t4.full_pushpop");
        chk("t4.count16", 32'(bus.count), 32'd16);
        chk("t4.no_overrun", 32'(bus.overrun), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t4.rel");
        repeat (15) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t4.pop");
        chk("t4.aa_last", 32'(bus.rd_data), 32'hAA);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t4.pop_aa");
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, "t4.wrap_pair");
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t4.wrap_rel");
        end

        // Randomized traffic: uart_rx-style handshake, random reads/acks/clears/enables
        bus.int_en = 1'b1;
        rdy_l = 1'b0;
        d_l   = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (rdy_l && bus.rx_clear) rdy_l = 1'b0;
            else if (!rdy_l && !bus.rx_clear && ($urandom_range(0, 1) == 1)) begin
                rdy_l = 1'b1;
                d_l   = 8'($urandom);
            end
            if ($urandom_range(0, 31) == 0) bus.int_en = ~bus.int_en;
            step(rdy_l, d_l, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, "rand");
        end

        // 5: pop on empty ignored; interrupt gated by int_en
        bus.rx_data_ready = 1'b0;
        do_reset();
        bus.int_en = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t5.pop_empty");
        chk("t5.count0", 32'(bus.count), 32'd0);
        chk("t5.rd_zero", 32'(bus.rd_data), 32'h00);
        bus.int_en = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t5.idle");
        chk("t5.masked", 32'(bus.int_n), 32'd1);
        bus.int_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t5.enable");
        chk("t5.int_n_low", 32'(bus.int_n), 32'd0);

        // 6: reset while a byte is mid-handshake with entries held
        do_reset();
        bus.int_en = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "t6.cap");
        chk("t6.count5", 32'(bus.count), 32'd5);
        chk("t6.in_wait", 32'(bus.rx_clear), 32'd1);
        do_reset();
        chk("t6.count0", 32'(bus.count), 32'd0);
        chk("t6.rx_clear0", 32'(bus.rx_clear), 32'd0);
        chk("t6.overrun0", 32'(bus.overrun), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t6.rel");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
